// File: rtl/pipelined_fixed_adder.sv
// Pipelined two's-complement add/subtract: N bits split into STAGES carry-chained segments.
// Define ADDER_SATURATE_EN to clamp the result on signed overflow instead of wrapping.
module pipelined_fixed_adder #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_subtract,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         overflow_flag,
    output logic         negative,
    output logic         zero
);
    localparam int W = N / STAGES;

    if ((N % STAGES) != 0) begin : g_badConfig
        $error("pipelined_fixed_adder: N must be a multiple of STAGES");
    end

    logic         advance;
    logic [N-1:0] bEff;

    logic [N-1:0] lastRes;
    logic         lastCarry;
    logic         lastSignA;
    logic         lastSignB;
    logic         lastValid;

    logic [N-1:0] result_d;
    logic         overflow_d;
    logic         negative_d;
    logic         zero_d;

    logic [N-1:0] outResult_q;
    logic         outValid_q;
    logic         outCarry_q;
    logic         outOverflow_q;
    logic         outNegative_q;
    logic         outZero_q;

    assign advance  = !outValid_q || out_ready;
    assign in_ready = advance;
    assign bEff     = is_subtract ? ~b : b;

    // Stage k consumes the low segment of the operands it still holds; the upper
    // operand bits ride along (skew) and finished result bits accumulate (deskew).
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM = N - k * W;

        logic [REM-1:0]     opA;
        logic [REM-1:0]     opB;
        logic               cin;
        logic               vIn;
        logic [W:0]         segSum;
        logic [(k+1)*W-1:0] partial;

        if (k == 0) begin : g_in
            assign opA     = a;
            assign opB     = bEff;
            assign cin     = is_subtract;
            assign vIn     = in_valid;
            assign partial = segSum[W-1:0];
        end else begin : g_in
            assign opA     = g_stage[k-1].g_reg.opA_q;
            assign opB     = g_stage[k-1].g_reg.opB_q;
            assign cin     = g_stage[k-1].g_reg.segCarry_q;
            assign vIn     = g_stage[k-1].g_reg.valid_q;
            assign partial = {segSum[W-1:0], g_stage[k-1].g_reg.res_q};
        end

        assign segSum = {1'b0, opA[W-1:0]} + {1'b0, opB[W-1:0]} + {{W{1'b0}}, cin};

        if (k < STAGES - 1) begin : g_reg
            logic [REM-W-1:0]   opA_q;
            logic [REM-W-1:0]   opB_q;
            logic [(k+1)*W-1:0] res_q;
            logic               segCarry_q;
            logic               valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    opA_q      <= '0;
                    opB_q      <= '0;
                    res_q      <= '0;
                    segCarry_q <= 1'b0;
                    valid_q    <= 1'b0;
                end else if (advance) begin
                    opA_q      <= opA[REM-1:W];
                    opB_q      <= opB[REM-1:W];
                    res_q      <= partial;
                    segCarry_q <= segSum[W];
                    valid_q    <= vIn;
                end
            end
        end else begin : g_last
            assign lastRes   = partial;
            assign lastCarry = segSum[W];
            assign lastSignA = opA[W-1];
            assign lastSignB = opB[W-1];
            assign lastValid = vIn;
        end
    end

    // Sign-agreement test on the effective operands equals carry-in(MSB) XOR carry-out.
    always_comb begin
        overflow_d = (lastSignA == lastSignB) && (lastRes[N-1] != lastSignA);
        negative_d = overflow_d ^ lastRes[N-1];
        result_d   = lastRes;
`ifdef ADDER_SATURATE_EN
        if (overflow_d) begin
            result_d = negative_d ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q    <= 1'b0;
            outResult_q   <= '0;
            outCarry_q    <= 1'b0;
            outOverflow_q <= 1'b0;
            outNegative_q <= 1'b0;
            outZero_q     <= 1'b0;
        end else if (advance) begin
            outValid_q    <= lastValid;
            outResult_q   <= result_d;
            outCarry_q    <= lastCarry;
            outOverflow_q <= overflow_d;
            outNegative_q <= negative_d;
            outZero_q     <= zero_d;
        end
    end

    assign out_valid     = outValid_q;
    assign result        = outResult_q;
    assign carry         = outCarry_q;
    assign overflow_flag = outOverflow_q;
    assign negative      = outNegative_q;
    assign zero          = outZero_q;

endmodule

// File: tb/tb_pipelined_fixed_adder.sv
// Directed self-checking bench for pipelined_fixed_adder (N=16, STAGES overridable).
// Expectations follow ADDER_SATURATE_EN when it is defined.
module tb_pipelined_fixed_adder;
    parameter int STAGES = 4;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         is_subtract;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         carry;
    logic         overflow_flag;
    logic         negative;
    logic         zero;

    int vectorCount = 0;
    int missCount   = 0;

`ifdef ADDER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    pipelined_fixed_adder #(.N(N), .STAGES(STAGES)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .is_subtract  (is_subtract),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .carry        (carry),
        .overflow_flag(overflow_flag),
        .negative     (negative),
        .zero         (zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One isolated operation with out_ready held high; checks latency and all flags.
    task automatic applyStimulus(input string tag, input logic [N-1:0] opA, input logic [N-1:0] opB,
                                 input logic sub, input logic [N-1:0] expRes, input logic expC,
                                 input logic expV, input logic expN, input logic expZ);
        int lat;
        @(negedge clk);
        a           = opA;
        b           = opB;
        is_subtract = sub;
        in_valid    = 1'b1;
        #1;
        checkOutput({tag, ".inReady"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, ".latency"}, 32'(lat), 32'(STAGES));
        checkOutput({tag, ".result"}, 32'(result), 32'(expRes));
        checkOutput({tag, ".carry"}, 32'(carry), 32'(expC));
        checkOutput({tag, ".overflow"}, 32'(overflow_flag), 32'(expV));
        checkOutput({tag, ".negative"}, 32'(negative), 32'(expN));
        checkOutput({tag, ".zero"}, 32'(zero), 32'(expZ));
    endtask

    logic [N-1:0] streamA   [8] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333,
                                    16'h4444, 16'h5555, 16'h6666, 16'h7777};
    logic [N-1:0] streamB   [8] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103,
                                    16'h0104, 16'h0105, 16'h0106, 16'h0107};
    logic [N-1:0] streamExp [8] = '{16'h0100, 16'h1212, 16'h2324, 16'h3436,
                                    16'h4548, 16'h565A, 16'h676C, 16'h787E};

    initial begin
        int sent;
        int recv;
        int firstValid;
        logic stall;
        logic [N-1:0] heldRes;
        logic sawValid;

        rst         = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        is_subtract = 1'b0;
        out_ready   = 1'b1;
        #1;
        checkOutput("reset.outValid", 32'(out_valid), 32'd0);
        checkOutput("reset.result", 32'(result), 32'd0);
        checkOutput("reset.flags", 32'({carry, overflow_flag, negative, zero}), 32'd0);
        checkOutput("reset.inReady", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("basicAdd", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("rippleAdd", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus("borrowSub", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("equalSub", 16'h0001, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus("posOverflow", 16'h7FFF, 16'h0001, 1'b0,
                      SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("negOverflowSub", 16'h8000, 16'h0001, 1'b1,
                      SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus("negOverflowAdd", 16'h8000, 16'h8000, 1'b0,
                      SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, 1'b1, !SAT);

        // Streaming with a 3-cycle stall starting at the first valid output.
        sent       = 0;
        recv       = 0;
        firstValid = -1;
        heldRes    = '0;
        for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
            @(negedge clk);
            if (out_valid && firstValid < 0) firstValid = cyc;
            stall     = (firstValid >= 0) && (cyc < firstValid + 3);
            out_ready = !stall;
            if (sent < 8) begin
                in_valid    = 1'b1;
                a           = streamA[sent];
                b           = streamB[sent];
                is_subtract = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall) begin
                checkOutput("stream.inReadyLow", 32'(in_ready), 32'd0);
                if (cyc == firstValid) heldRes = result;
                else checkOutput("stream.heldResult", 32'(result), 32'(heldRes));
            end
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream.result%0d", recv), 32'(result), 32'(streamExp[recv]));
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        checkOutput("stream.count", 32'(recv), 32'd8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("stream.noExtra", 32'(out_valid), 32'd0);

        // Reset while two operations are in flight.
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; is_subtract = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 16'h0002; b = 16'h0002;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checkOutput("midReset.outValid", 32'(out_valid), 32'd0);
        checkOutput("midReset.result", 32'(result), 32'd0);
        checkOutput("midReset.flags", 32'({carry, overflow_flag, negative, zero}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midReset.inReady", 32'(in_ready), 32'd1);
        sawValid = 1'b0;
        for (int i = 0; i < STAGES + 4; i++) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("midReset.noStale", 32'(sawValid), 32'd0);
        applyStimulus("afterReset", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
